firc_sample_fifo: RTL

- Input sample buffer directly upstream of the firc complex FIR filter.
- Accepts 24-bit I/Q samples from the sample source and stores them in a small FIFO.
- Presents samples to firc on its PushIn/SampI/SampQ inputs and honours firc's StopIn backpressure.
- Issues early stop to the source, so a producer that reacts one cycle late never loses samples; any sample dropped anyway is counted.

---
 rtl/firc_sample_fifo.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/firc_sample_fifo.sv
// firc_sample_fifo
//   Input sample buffer placed directly in front of the firc complex FIR.
//   Stores I/Q sample pairs from the source in a small first-word-fall-through
//   FIFO. It presents the head sample to firc and honours firc's stop signal.
//   It raises an early stop to the source so that a producer reacting one
//   cycle late still fits. Samples that arrive while full (and nothing leaves
//   in that cycle) are dropped and counted.
//
// Ports
//   Clk       in   rising-edge clock
//   Reset     in   synchronous active-high reset, highest priority
//   SrcPush   in   source offers {SrcI,SrcQ} this cycle
//   SrcI/SrcQ in   source sample rails, two's complement, SW bits each
//   SrcStop   out  occupancy >= DEPTH-STOP_MARGIN (advisory to the source)
//   FirPush   out  head sample valid on FirI/FirQ (drives firc PushIn)
//   FirI/FirQ out  head sample rails, forced to 0 while empty
//   FirStop   in   firc not accepting; head holds while asserted
//   Count     out  current occupancy, 0..DEPTH
//   Overflow  out  sticky: a sample has been dropped since reset
//   DropCnt   out  dropped-sample count, saturating at 255
module firc_sample_fifo #(
    parameter int DEPTH       = 16,
    parameter int SW          = 24,
    parameter int STOP_MARGIN = 2
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   SrcPush,
    input  logic [SW-1:0]          SrcI,
    input  logic [SW-1:0]          SrcQ,
    output logic                   SrcStop,
    output logic                   FirPush,
    output logic [SW-1:0]          FirI,
    output logic [SW-1:0]          FirQ,
    input  logic                   FirStop,
    output logic [$clog2(DEPTH):0] Count,
    output logic                   Overflow,
    output logic [7:0]             DropCnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] STOP_LVL = CW'(DEPTH - STOP_MARGIN);

    // Sample storage: I rail in the upper half, Q rail in the lower half so
    // the two rails of a sample can never separate.
    logic [2*SW-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;

    logic          empty;
    logic          full;
    logic          pop;
    logic          wr_en;
    logic          drop;
    logic [2*SW-1:0] wr_data;
    logic [2*SW-1:0] head;

    // Transfer decisions. A write into a full FIFO is still accepted when the
    // head leaves in the same cycle, because that frees exactly one slot.
    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == FULL_LVL);
        pop     = !empty && !FirStop;
        wr_en   = SrcPush && (!full || pop);
        drop    = SrcPush && full && !pop;
        wr_data = {SrcI, SrcQ};
    end

    // Next-state for pointers, occupancy and drop bookkeeping.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        // DEPTH is a power of two, so natural AW-bit overflow gives mod DEPTH.
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage has no reset; stale contents are unreachable once the pointers
    // and count are cleared. Writes are suppressed during Reset anyway.
    always_ff @(posedge Clk) begin
        if (wr_en && !Reset) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // First-word fall-through: the head entry is read asynchronously so a
    // sample written at one edge is presented in the very next cycle.
    always_comb begin
        head    = mem_q[rd_ptr_q];
        FirPush = !empty;
        FirI    = empty ? '0 : head[2*SW-1:SW];
        FirQ    = empty ? '0 : head[SW-1:0];
        SrcStop = (count_q >= STOP_LVL);
        Count   = count_q;
        Overflow = overflow_q;
        DropCnt  = drop_cnt_q;
    end

endmodule
